// File: rtl/imem_rr_arbiter_pkg.sv
// imem_pkg: shared definitions for the instruction-ROM arbiter.
//   NUM_CPUS_DEF / ROM_SIZE_DEF : default system sizing
//   INSTR_W / instr_t           : instruction word
//   rr_pick()                   : round-robin winner search, usable by RTL and models
package imem_pkg;

  localparam int NUM_CPUS_DEF = 3;
  localparam int ROM_SIZE_DEF = 32;
  localparam int INSTR_W      = 32;

  // Upper bound on requesters the picker function can scan.
  localparam int MAX_CPUS = 32;
  localparam int IDX_W    = $clog2(MAX_CPUS);

  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    logic             any;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan ptr+1, ptr+2, ... modulo n; first set request bit wins.
  // ptr < n and k <= n keep ptr+k below 2n, so one subtraction wraps it.
  function automatic pick_t rr_pick(input logic [MAX_CPUS-1:0] req,
                                    input int ptr,
                                    input int n);
    pick_t p;
    int    j;
    p.any = 1'b0;
    p.idx = '0;
    for (int k = 1; k <= MAX_CPUS; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if ((k <= n) && !p.any && req[j[IDX_W-1:0]]) begin
        p.any = 1'b1;
        p.idx = j[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/imem_rr_arbiter_pick.sv
// rr_pick_comb: combinational round-robin picker.
//   req : request vector        ptr : index of the last winner
//   gnt : one-hot grant         idx : winning index   any : some request won
module rr_pick_comb
  import imem_pkg::*;
#(
  parameter int N  = NUM_CPUS_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  pick_t pick;

  always_comb begin
    pick = rr_pick(MAX_CPUS'(req), int'(ptr), N);
    gnt  = '0;
    any  = pick.any;
    idx  = pick.idx[PW-1:0];
    if (pick.any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/imem_rr_arbiter.sv
// imem_rr_arbiter: round-robin arbiter in front of the shared instruction ROM.
//   req/addr   : per-CPU fetch request and word address
//   gnt        : one-hot combinational grant (request accepted this cycle)
//   rom_a/rom_rd : ROM read port (address out, combinational data in)
//   rsp_valid/rsp_data : registered response, one cycle after the grant
//   grant_cnt  : per-CPU saturating grant counters
module imem_rr_arbiter
  import imem_pkg::*;
#(
  parameter int NUM_CPUS = NUM_CPUS_DEF,
  parameter int ROM_SIZE = ROM_SIZE_DEF,
  parameter int ADDR_W   = $clog2(ROM_SIZE),
  parameter int CNT_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CPUS-1:0]            req,
  input  logic [NUM_CPUS-1:0][ADDR_W-1:0] addr,
  output logic [NUM_CPUS-1:0]            gnt,
  output logic [NUM_CPUS-1:0]            rsp_valid,
  output instr_t                         rsp_data,
  output logic [ADDR_W-1:0]              rom_a,
  input  instr_t                         rom_rd,
  output logic [NUM_CPUS-1:0][CNT_W-1:0] grant_cnt
);

  localparam int PW = $clog2(NUM_CPUS);
  // Last winner resets to the highest index so CPU0 is scanned first.
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_CPUS - 1);

  logic [PW-1:0]                  ptr_p0;
  logic [PW-1:0]                  win_idx;
  logic                           win_any;
  logic [NUM_CPUS-1:0]            vld_p1;
  instr_t                         rsp_data_p1;
  logic [NUM_CPUS-1:0][CNT_W-1:0] cnt_p1;

  rr_pick_comb #(.N(NUM_CPUS), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr_p0),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Stage p0: arbitration and ROM address, combinational from ptr_p0.
  assign rom_a = win_any ? addr[win_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr_p0 <= PTR_RST;
    else if (win_any) ptr_p0 <= win_idx;
  end

  // Stage p1: registered ROM data and owner; data holds on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= '0;
      rsp_data_p1 <= '0;
    end else begin
      vld_p1 <= gnt;
      if (win_any) rsp_data_p1 <= rom_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_CPUS; i++) begin
        if (gnt[i] && (cnt_p1[i] != {CNT_W{1'b1}}))
          cnt_p1[i] <= cnt_p1[i] + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_data  = rsp_data_p1;
  assign grant_cnt = cnt_p1;

endmodule

// File: tb/tb_imem_rr_arbiter.sv
module tb_imem_rr_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req;
  logic [2:0][4:0]  addr;
  logic [2:0]       gnt, rsp_valid;
  logic [31:0]      rsp_data, rom_rd;
  logic [4:0]       rom_a;
  logic [2:0][15:0] gcnt;

  logic [2:0]       gnt4, rsp_valid4;
  logic [31:0]      rsp_data4, rom_rd4;
  logic [4:0]       rom_a4;
  logic [2:0][3:0]  gcnt4;

  int checks = 0;
  int errors = 0;
  logic [34:0] sb[$];

  always #5 clk = ~clk;

  // ROM word at address a is 0xC0DE00aa.
  assign rom_rd  = {16'hC0DE, 11'd0, rom_a};
  assign rom_rd4 = {16'hC0DE, 11'd0, rom_a4};

  imem_rr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rom_a(rom_a),
    .rom_rd(rom_rd), .grant_cnt(gcnt)
  );

  imem_rr_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt4),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .rom_a(rom_a4),
    .rom_rd(rom_rd4), .grant_cnt(gcnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (rsp_valid != 3'b000)) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {29'd0, rsp_valid}, 32'd0);
      end else begin
        logic [34:0] e;
        e = sb.pop_front();
        chk("rsp_valid", {29'd0, rsp_valid}, {29'd0, e[34:32]});
        chk("rsp_data", rsp_data, e[31:0]);
      end
    end
  end

  // Entered at posedge+1; checks gnt mid-cycle and queues the expected response.
  task automatic tick(input logic [2:0] r, input logic [4:0] a2, input logic [4:0] a1,
                      input logic [4:0] a0, input logic [2:0] eg, input logic [31:0] ed);
    req  = r;
    addr = {a2, a1, a0};
    #3;
    chk("gnt", {29'd0, gnt}, {29'd0, eg});
    if (eg != 3'b000) sb.push_back({eg, ed});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_cnt", {gcnt[2], gcnt[1]}, 32'd0);
    chk("rst_cnt0", {16'd0, gcnt[0]}, 32'd0);
    chk("rst_rom_a", {27'd0, rom_a}, 32'd0);
    rst = 1'b0;

    // All three request: order 0,1,2,0,1,2.
    tick(3'b111, 5'd2, 5'd1, 5'd0, 3'b001, 32'hC0DE0000);
    tick(3'b111, 5'd2, 5'd1, 5'd0, 3'b010, 32'hC0DE0001);
    tick(3'b111, 5'd2, 5'd1, 5'd0, 3'b100, 32'hC0DE0002);
    tick(3'b111, 5'd2, 5'd1, 5'd0, 3'b001, 32'hC0DE0000);
    tick(3'b111, 5'd2, 5'd1, 5'd0, 3'b010, 32'hC0DE0001);
    tick(3'b111, 5'd2, 5'd1, 5'd0, 3'b100, 32'hC0DE0002);
    chk("cnt0_rr", {16'd0, gcnt[0]}, 32'd2);
    chk("cnt1_rr", {16'd0, gcnt[1]}, 32'd2);
    chk("cnt2_rr", {16'd0, gcnt[2]}, 32'd2);

    // Idle cycle: no response, data holds.
    tick(3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);
    chk("idle_rsp_valid", {29'd0, rsp_valid}, 32'd0);
    chk("idle_rsp_hold", rsp_data, 32'hC0DE0002);

    // Sole requester CPU1, back to back.
    tick(3'b010, 5'd0, 5'd7, 5'd0, 3'b010, 32'hC0DE0007);
    tick(3'b010, 5'd0, 5'd7, 5'd0, 3'b010, 32'hC0DE0007);
    tick(3'b010, 5'd0, 5'd7, 5'd0, 3'b010, 32'hC0DE0007);
    tick(3'b010, 5'd0, 5'd7, 5'd0, 3'b010, 32'hC0DE0007);

    // Last winner 1: CPU0 wins via wrap, then CPU1, then CPU0.
    tick(3'b011, 5'd0, 5'd7, 5'd3, 3'b001, 32'hC0DE0003);
    tick(3'b011, 5'd0, 5'd7, 5'd3, 3'b010, 32'hC0DE0007);
    tick(3'b011, 5'd0, 5'd7, 5'd3, 3'b001, 32'hC0DE0003);

    // Last winner 0: CPU1 beats CPU2.
    tick(3'b110, 5'd9, 5'd5, 5'd0, 3'b010, 32'hC0DE0005);

    // CPU2 granted mid-cycle, then reset before the edge: no response.
    req  = 3'b100;
    addr = {5'd9, 5'd0, 5'd0};
    #3;
    chk("gnt_pre_rst", {29'd0, gnt}, 32'h4);
    chk("rom_a_pre_rst", {27'd0, rom_a}, 32'd9);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
    chk("midrst_cnt1", {16'd0, gcnt[1]}, 32'd0);
    chk("midrst_cnt2", {16'd0, gcnt[2]}, 32'd0);
    @(posedge clk);
    #1;
    chk("inrst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    tick(3'b100, 5'd9, 5'd0, 5'd0, 3'b100, 32'hC0DE0009);
    chk("post_rst_cnt2", {16'd0, gcnt[2]}, 32'd1);
    tick(3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);

    // Saturation: CPU0 alone for 20 cycles.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      tick(3'b001, 5'd0, 5'd0, 5'd4, 3'b001, 32'hC0DE0004);
    tick(3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);
    chk("cnt16_cpu0", {16'd0, gcnt[0]}, 32'd20);
    chk("cnt4_sat", {28'd0, gcnt4[0]}, 32'd15);
    chk("cnt4_cpu1", {28'd0, gcnt4[1]}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
